// File: rtl/mem_rmw_pkg.sv
// Shared types and helpers for the memory read-modify-write request controller.
package mem_rmw_pkg;

  localparam int WORD_DEF = 32;
  localparam int ADDR_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RMW_RD,
    RMW_WR,
    CAPT,
    RESP
  } state_t;

  // Reference byte-lane merge for the default word width.
  function automatic logic [WORD_DEF-1:0] byte_merge(
    input logic [WORD_DEF-1:0]   old_word,
    input logic [WORD_DEF-1:0]   new_word,
    input logic [WORD_DEF/8-1:0] be
  );
    logic [WORD_DEF-1:0] r;
    r = old_word;
    for (int i = 0; i < WORD_DEF / 8; i++) begin
      if (be[i]) r[8*i +: 8] = new_word[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_byte_merge.sv
// Combinational byte-lane mux: enabled lanes take the new data, others keep the old word.
module mem_byte_merge
  import mem_rmw_pkg::*;
#(
  parameter int WORD = WORD_DEF,
  parameter int NBE  = WORD / 8
) (
  input  logic [WORD-1:0] old_word,
  input  logic [WORD-1:0] new_word,
  input  logic [NBE-1:0]  be,
  output logic [WORD-1:0] merged
);

  for (genvar gi = 0; gi < NBE; gi++) begin : g_lane
    assign merged[8*gi +: 8] = be[gi] ? new_word[8*gi +: 8] : old_word[8*gi +: 8];
  end

endmodule

// File: rtl/mem_rmw_ctrl.sv
// Single-outstanding load/store controller in front of a word-only memory;
// byte-masked stores are turned into read-modify-write sequences.
module mem_rmw_ctrl
  import mem_rmw_pkg::*;
#(
  parameter int WORD = WORD_DEF,
  parameter int ADDR = ADDR_DEF,
  parameter int NBE  = WORD / 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [31:0]     req_addr,
  input  logic [WORD-1:0] req_wdata,
  input  logic [NBE-1:0]  req_be,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [WORD-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [ADDR-1:0] mem_a,
  output logic            mem_w,
  output logic [WORD-1:0] mem_d,
  input  logic [WORD-1:0] mem_q
);

  state_t          state_reg;
  logic [WORD-1:0] wdata_reg;
  logic [NBE-1:0]  be_reg;
  logic [WORD-1:0] mem_d_reg;
  logic [WORD-1:0] merged;
  logic            addr_err;
  logic            unused_addr_lsb;

  assign addr_err        = |req_addr[31:ADDR+2];
  assign unused_addr_lsb = ^req_addr[1:0];
  assign req_ready       = (state_reg == IDLE);

  mem_byte_merge #(.WORD(WORD), .NBE(NBE)) u_merge (
    .old_word (mem_q),
    .new_word (wdata_reg),
    .be       (be_reg),
    .merged   (merged)
  );

  // Read data only arrives during RMW_WR, so the merged word bypasses the
  // register there and is then held so mem_d stays stable afterwards.
  assign mem_d = (state_reg == RMW_WR) ? merged : mem_d_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      wdata_reg <= '0;
      be_reg    <= '0;
      mem_d_reg <= '0;
      mem_a     <= '0;
      mem_w     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            wdata_reg <= req_wdata;
            be_reg    <= req_be;
            if (addr_err) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              rsp_valid <= 1'b1;
              state_reg <= RESP;
            end else if (!req_we) begin
              mem_a     <= req_addr[ADDR+1:2];
              mem_w     <= 1'b0;
              state_reg <= RD;
            end else if (&req_be) begin
              mem_a     <= req_addr[ADDR+1:2];
              mem_w     <= 1'b1;
              mem_d_reg <= req_wdata;
              state_reg <= WR;
            end else if (req_be == '0) begin
              rsp_err   <= 1'b0;
              rsp_rdata <= '0;
              rsp_valid <= 1'b1;
              state_reg <= RESP;
            end else begin
              mem_a     <= req_addr[ADDR+1:2];
              mem_w     <= 1'b0;
              state_reg <= RMW_RD;
            end
          end
        end
        RD: state_reg <= CAPT;
        CAPT: begin
          rsp_rdata <= mem_q;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state_reg <= RESP;
        end
        WR: begin
          mem_w     <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state_reg <= RESP;
        end
        RMW_RD: begin
          mem_w     <= 1'b1;
          state_reg <= RMW_WR;
        end
        RMW_WR: begin
          mem_w     <= 1'b0;
          mem_d_reg <= merged;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state_reg <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Randomized and directed bench for mem_rmw_ctrl against a word-array memory
// and a behavioural model of memory contents and response timing.
module tb_mem_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] mem_a;
  logic        mem_w;
  logic [31:0] mem_d;
  logic [31:0] mem_q = '0;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] mem [0:65535];
  logic [31:0] model_mem [int];
  int          edge_cnt = 0;
  int          wr_cnt = 0;
  int          wr_edge = 0;
  logic [15:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  always #5 clk = ~clk;

  mem_rmw_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_a     (mem_a),
    .mem_w     (mem_w),
    .mem_d     (mem_d),
    .mem_q     (mem_q)
  );

  // Memory: write-only on write cycles, output register keeps stale data then.
  always @(posedge clk) begin
    edge_cnt++;
    if (mem_w) begin
      mem[mem_a] <= mem_d;
      wr_cnt++;
      wr_edge = edge_cnt;
      wr_addr = mem_a;
      wr_data = mem_d;
    end else begin
      mem_q <= mem[mem_a];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] model_rd(input int wa);
    return model_mem.exists(wa) ? model_mem[wa] : 32'h0;
  endfunction

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int hold);
    logic        err;
    int          wa, exp_lat, exp_wr, exp_off, lat, acc_edge, wr0, t;
    logic [31:0] exp_rd, new_word, mask;
    err      = |addr[31:18];
    wa       = int'(addr[17:2]);
    exp_rd   = 32'h0;
    exp_wr   = 0;
    exp_off  = 0;
    new_word = 32'h0;
    mask     = 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
    if (err) exp_lat = 1;
    else if (!we) begin exp_lat = 3; exp_rd = model_rd(wa); end
    else if (be == 4'h0) exp_lat = 1;
    else if (be == 4'hF) begin exp_lat = 2; exp_wr = 1; exp_off = 1; new_word = wd; end
    else begin
      exp_lat = 3; exp_wr = 1; exp_off = 2;
      new_word = (model_rd(wa) & ~mask) | (wd & mask);
    end

    t = 0;
    while (!req_ready && t < 20) begin @(posedge clk); #1; t++; end
    chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    wr0 = wr_cnt;
    @(posedge clk); #1;
    acc_edge  = edge_cnt;
    req_valid = 1'b0;
    req_we    = $urandom_range(0, 1);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);

    lat = 1;
    while (!rsp_valid && lat < 8) begin @(posedge clk); #1; lat++; end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rsp_err", {31'h0, rsp_err}, {31'h0, err});
    chk("rsp_rdata", rsp_rdata, exp_rd);

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'h0, rsp_valid}, 32'h1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_err", {31'h0, rsp_err}, {31'h0, err});
      chk("hold_busy", {31'h0, req_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_drop", {31'h0, rsp_valid}, 32'h0);
    chk("back_idle", {31'h0, req_ready}, 32'h1);

    chk("write_count", 32'(wr_cnt - wr0), 32'(exp_wr));
    if (exp_wr == 1) begin
      chk("write_cycle", 32'(wr_edge - acc_edge), 32'(exp_off));
      chk("write_addr", {16'h0, wr_addr}, 32'(wa));
      chk("write_data", wr_data, new_word);
      model_mem[wa] = new_word;
      chk("mem_word", mem[wa], new_word);
    end
    $display("txn we=%0d addr=%h wd=%h be=%h lat=%0d rd=%h err=%0d hold=%0d",
             we, addr, wd, be, lat, rsp_rdata, rsp_err, hold);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
    chk({tag, "_rsp_err"}, {31'h0, rsp_err}, 32'h0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_mem_w"}, {31'h0, mem_w}, 32'h0);
    chk({tag, "_mem_a"}, {16'h0, mem_a}, 32'h0);
    chk({tag, "_mem_d"}, mem_d, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  b;
    int          wr0;
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_ready", {31'h0, req_ready}, 32'h1);

    do_req(1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 0);
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0);
    do_req(1'b1, 32'h0000_0010, 32'h0000_00AA, 4'b0001, 0);
    do_req(1'b0, 32'h0000_0012, 32'h0, 4'h3, 0);
    do_req(1'b0, 32'h0004_0000, 32'h0, 4'h0, 1);
    do_req(1'b1, 32'h8000_0010, 32'h12345678, 4'hF, 0);
    do_req(1'b1, 32'h0000_0020, 32'hCAFEF00D, 4'h0, 0);
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0, 5);

    // Reset in the read half of a partial store must leave memory untouched.
    do_req(1'b1, 32'h0000_0020, 32'h11223344, 4'hF, 0);
    while (!req_ready) begin @(posedge clk); #1; end
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5; req_be = 4'b0011;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wr0 = wr_cnt;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_no_write", 32'(wr_cnt - wr0), 32'h0);
    chk("midrst_mem", mem[8], 32'h11223344);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready", {31'h0, req_ready}, 32'h1);
    do_req(1'b0, 32'h0000_0020, 32'h0, 4'h0, 0);

    for (int n = 0; n < 60; n++) begin
      a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
      if ($urandom_range(0, 9) == 0) a[18 + $urandom_range(0, 13)] = 1'b1;
      case ($urandom_range(0, 3))
        0:       b = 4'h0;
        1:       b = 4'hF;
        default: b = 4'($urandom);
      endcase
      do_req(1'($urandom), a, $urandom, b, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
